// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl_pkg
// Description : Shared pipeline-control definitions: hazard FSM state
//               encoding, mul/div wait-counter width and default timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_stall_ctrl_pkg;

  // Hazard controller FSM state encoding
  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MD_WAIT = 1'b1;

  // Mul/div wait counter: 6 bits, saturating at 63
  localparam int WAIT_CNT_W = 6;

  // Default number of mul/div wait cycles before the timeout flag sets
  localparam int MD_TIMEOUT_CYC_DEFAULT = 40;

endpackage : hazard_stall_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_stall_ctrl_perf_counter.sv
`default_nettype none
// ============================================================================
// Module      : perf_counter
// Description : Free-running event counter with synchronous clear and
//               natural wrap-around at 2**WIDTH.
// Ports       : clk   - clock
//               clr   - synchronous clear (priority over en)
//               en    - count enable
//               count - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module perf_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule : perf_counter
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Pipeline stall/flush controller. Decodes load-use hazards,
//               taken branches, multi-cycle mul/div ops and data-memory
//               back-pressure into pipeline register enables and bubbles.
// Ports       : CLK, RESET (sync, active high)
//               LOAD_USE_HAZ, BRANCH_TAKEN, MULDIV_OP, MULDIV_DONE,
//               DMEM_BUSY                      - hazard requests
//               *_WRITE_EN                     - pipeline register loads
//               IF_ID_FLUSH, *_BUBBLE          - force NOP into register
//               MULDIV_GO                      - mul/div start pulse
//               MD_TIMEOUT                     - sticky mul/div timeout
//               STALL_CNT                      - cycles with PC frozen
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT_CYC = MD_TIMEOUT_CYC_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        LOAD_USE_HAZ,
  input  logic        BRANCH_TAKEN,
  input  logic        MULDIV_OP,
  input  logic        MULDIV_DONE,
  input  logic        DMEM_BUSY,
  output logic        PC_WRITE_EN,
  output logic        IF_ID_WRITE_EN,
  output logic        ID_EX_WRITE_EN,
  output logic        EX_MEM_WRITE_EN,
  output logic        MEM_WB_WRITE_EN,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_BUBBLE,
  output logic        EX_MEM_BUBBLE,
  output logic        MULDIV_GO,
  output logic        MD_TIMEOUT,
  output logic [31:0] STALL_CNT
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LIM = WAIT_CNT_W'(MD_TIMEOUT_CYC);

  logic [0:0]            state;
  logic [0:0]            state_next;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [WAIT_CNT_W-1:0] wait_cnt_inc;
  logic                  md_waiting;
  logic                  timeout_flag;

  // A wait cycle is one spent in MD_WAIT with no result and no memory freeze;
  // memory back-pressure must not eat into the mul/div timeout budget.
  assign md_waiting   = (state == ST_MD_WAIT) && !MULDIV_DONE && !DMEM_BUSY;
  assign wait_cnt_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
  assign MD_TIMEOUT   = timeout_flag;

  // --------------------------------------------------------------------------
  // Enable / bubble decode. Priority: reset, memory freeze, then FSM.
  // --------------------------------------------------------------------------
  always_comb begin
    PC_WRITE_EN     = 1'b1;
    IF_ID_WRITE_EN  = 1'b1;
    ID_EX_WRITE_EN  = 1'b1;
    EX_MEM_WRITE_EN = 1'b1;
    MEM_WB_WRITE_EN = 1'b1;
    IF_ID_FLUSH     = 1'b0;
    ID_EX_BUBBLE    = 1'b0;
    EX_MEM_BUBBLE   = 1'b0;
    MULDIV_GO       = 1'b0;
    state_next      = state;

    if (RESET) begin
      PC_WRITE_EN     = 1'b0;
      IF_ID_WRITE_EN  = 1'b0;
      ID_EX_WRITE_EN  = 1'b0;
      EX_MEM_WRITE_EN = 1'b0;
      MEM_WB_WRITE_EN = 1'b0;
      IF_ID_FLUSH     = 1'b1;
      ID_EX_BUBBLE    = 1'b1;
      EX_MEM_BUBBLE   = 1'b1;
    end else if (DMEM_BUSY) begin
      // Full freeze; the mul/div start is simply not issued, and since the
      // FSM stays in RUN it is re-issued once memory is ready again.
      PC_WRITE_EN     = 1'b0;
      IF_ID_WRITE_EN  = 1'b0;
      ID_EX_WRITE_EN  = 1'b0;
      EX_MEM_WRITE_EN = 1'b0;
      MEM_WB_WRITE_EN = 1'b0;
    end else if (state == ST_RUN) begin
      if (BRANCH_TAKEN) begin
        // Squash wrong-path IF/ID and ID/EX; PC keeps moving to the target
        // even if a load-use stall was also requested.
        IF_ID_FLUSH  = 1'b1;
        ID_EX_BUBBLE = 1'b1;
      end else if (MULDIV_OP) begin
        MULDIV_GO       = 1'b1;
        PC_WRITE_EN     = 1'b0;
        IF_ID_WRITE_EN  = 1'b0;
        ID_EX_WRITE_EN  = 1'b0;
        EX_MEM_WRITE_EN = 1'b0;
        EX_MEM_BUBBLE   = 1'b1;
        state_next      = ST_MD_WAIT;
      end else if (LOAD_USE_HAZ) begin
        PC_WRITE_EN    = 1'b0;
        IF_ID_WRITE_EN = 1'b0;
        ID_EX_BUBBLE   = 1'b1;
      end
    end else begin
      if (MULDIV_DONE) begin
        // Result available: release everything, hazards ignored this cycle
        state_next = ST_RUN;
      end else begin
        PC_WRITE_EN     = 1'b0;
        IF_ID_WRITE_EN  = 1'b0;
        ID_EX_WRITE_EN  = 1'b0;
        EX_MEM_WRITE_EN = 1'b0;
        EX_MEM_BUBBLE   = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM state, wait counter and sticky timeout
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= ST_RUN;
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state <= state_next;
      if (md_waiting) begin
        wait_cnt <= wait_cnt_inc;
        // Flag rises on the same edge the counter reaches the limit
        if (wait_cnt_inc >= TIMEOUT_LIM) begin
          timeout_flag <= 1'b1;
        end
      end else if (!DMEM_BUSY) begin
        // Outside a wait (or on the release cycle) the counter restarts
        if (state != ST_MD_WAIT || MULDIV_DONE) begin
          wait_cnt <= '0;
        end
      end
    end
  end

  // Reset cycles do not count as stalls even though PC_WRITE_EN is low
  perf_counter #(
    .WIDTH (32)
  ) u_stall_cnt (
    .clk   (CLK),
    .clr   (RESET),
    .en    (!PC_WRITE_EN),
    .count (STALL_CNT)
  );

endmodule : hazard_stall_ctrl
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_ctrl
// Description : Self-checking bench for hazard_stall_ctrl. Expected output
//               vectors and stall counts are queued as stimulus is applied
//               and compared against captured DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

  // Output vector order:
  // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB, IF_ID_FLUSH, ID_EX_BUB, EX_MEM_BUB, GO, TIMEOUT}
  localparam logic [9:0] V_RUN   = 10'b11111_000_0_0;
  localparam logic [9:0] V_LDUSE = 10'b00111_010_0_0;
  localparam logic [9:0] V_BR    = 10'b11111_110_0_0;
  localparam logic [9:0] V_GO    = 10'b00001_001_1_0;
  localparam logic [9:0] V_FRZ   = 10'b00001_001_0_0;
  localparam logic [9:0] V_BUSY  = 10'b00000_000_0_0;
  localparam logic [9:0] V_RST   = 10'b00000_111_0_0;
  localparam logic [9:0] V_TO    = 10'b00000_000_0_1;

  typedef struct packed {
    logic [9:0]  outs;
    logic [31:0] stall;
  } rec_t;

  logic        CLK;
  logic        RESET;
  logic        LOAD_USE_HAZ;
  logic        BRANCH_TAKEN;
  logic        MULDIV_OP;
  logic        MULDIV_DONE;
  logic        DMEM_BUSY;
  logic        PC_WRITE_EN;
  logic        IF_ID_WRITE_EN;
  logic        ID_EX_WRITE_EN;
  logic        EX_MEM_WRITE_EN;
  logic        MEM_WB_WRITE_EN;
  logic        IF_ID_FLUSH;
  logic        ID_EX_BUBBLE;
  logic        EX_MEM_BUBBLE;
  logic        MULDIV_GO;
  logic        MD_TIMEOUT;
  logic [31:0] STALL_CNT;

  rec_t        exp_q[$];
  rec_t        obs_q[$];
  logic [31:0] exp_stall;
  int          n_checks;
  int          n_fail;

  hazard_stall_ctrl #(
    .MD_TIMEOUT_CYC (40)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .LOAD_USE_HAZ    (LOAD_USE_HAZ),
    .BRANCH_TAKEN    (BRANCH_TAKEN),
    .MULDIV_OP       (MULDIV_OP),
    .MULDIV_DONE     (MULDIV_DONE),
    .DMEM_BUSY       (DMEM_BUSY),
    .PC_WRITE_EN     (PC_WRITE_EN),
    .IF_ID_WRITE_EN  (IF_ID_WRITE_EN),
    .ID_EX_WRITE_EN  (ID_EX_WRITE_EN),
    .EX_MEM_WRITE_EN (EX_MEM_WRITE_EN),
    .MEM_WB_WRITE_EN (MEM_WB_WRITE_EN),
    .IF_ID_FLUSH     (IF_ID_FLUSH),
    .ID_EX_BUBBLE    (ID_EX_BUBBLE),
    .EX_MEM_BUBBLE   (EX_MEM_BUBBLE),
    .MULDIV_GO       (MULDIV_GO),
    .MD_TIMEOUT      (MD_TIMEOUT),
    .STALL_CNT       (STALL_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Apply one cycle of inputs, queue the expectation, capture the DUT at the
  // falling edge, then advance the stall-count model across the rising edge.
  task automatic drive_step(input logic ld, input logic br, input logic op,
                            input logic done, input logic busy, input logic rst,
                            input logic [9:0] e);
    rec_t r;
    LOAD_USE_HAZ = ld;
    BRANCH_TAKEN = br;
    MULDIV_OP    = op;
    MULDIV_DONE  = done;
    DMEM_BUSY    = busy;
    RESET        = rst;
    r.outs  = e;
    r.stall = exp_stall;
    exp_q.push_back(r);
    @(negedge CLK);
    r.outs  = {PC_WRITE_EN, IF_ID_WRITE_EN, ID_EX_WRITE_EN, EX_MEM_WRITE_EN,
               MEM_WB_WRITE_EN, IF_ID_FLUSH, ID_EX_BUBBLE, EX_MEM_BUBBLE,
               MULDIV_GO, MD_TIMEOUT};
    r.stall = STALL_CNT;
    obs_q.push_back(r);
    @(posedge CLK);
    if (rst)        exp_stall = '0;
    else if (!e[9]) exp_stall = exp_stall + 1;
    #1;
  endtask

  task automatic test_reset();
    rec_t e, o;
    drive_step(0, 0, 0, 0, 0, 1, V_RST);
    drive_step(0, 0, 1, 0, 0, 1, V_RST);
    drive_step(0, 0, 0, 0, 0, 0, V_RUN);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.outs !== e.outs) begin
        n_fail++;
        $display("FAIL reset_outs: got %b expected %b", o.outs, e.outs);
      end
      n_checks++;
      if (o.stall !== e.stall) begin
        n_fail++;
        $display("FAIL reset_stall: got %0d expected %0d", o.stall, e.stall);
      end
    end
  endtask

  task automatic test_load_use();
    rec_t e, o;
    drive_step(1, 0, 0, 0, 0, 0, V_LDUSE);
    drive_step(0, 0, 0, 0, 0, 0, V_RUN);
    drive_step(1, 0, 0, 0, 0, 0, V_LDUSE);
    drive_step(1, 0, 0, 0, 0, 0, V_LDUSE);
    drive_step(0, 0, 0, 0, 0, 0, V_RUN);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.outs !== e.outs) begin
        n_fail++;
        $display("FAIL load_use_outs: got %b expected %b", o.outs, e.outs);
      end
      n_checks++;
      if (o.stall !== e.stall) begin
        n_fail++;
        $display("FAIL load_use_stall: got %0d expected %0d", o.stall, e.stall);
      end
    end
  endtask

  task automatic test_branch();
    rec_t e, o;
    drive_step(1, 1, 0, 0, 0, 0, V_BR);
    drive_step(0, 1, 0, 0, 0, 0, V_BR);
    drive_step(0, 1, 1, 0, 0, 0, V_BR);
    drive_step(0, 0, 0, 0, 0, 0, V_RUN);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.outs !== e.outs) begin
        n_fail++;
        $display("FAIL branch_outs: got %b expected %b", o.outs, e.outs);
      end
      n_checks++;
      if (o.stall !== e.stall) begin
        n_fail++;
        $display("FAIL branch_stall: got %0d expected %0d", o.stall, e.stall);
      end
    end
  endtask

  task automatic test_muldiv();
    rec_t e, o;
    drive_step(0, 0, 1, 0, 0, 0, V_GO);
    for (int i = 0; i < 5; i++) drive_step(i[0], i[1], 1, 0, 0, 0, V_FRZ);
    drive_step(1, 1, 1, 1, 0, 0, V_RUN);
    drive_step(1, 0, 0, 0, 0, 0, V_LDUSE);
    drive_step(0, 0, 0, 0, 0, 0, V_RUN);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.outs !== e.outs) begin
        n_fail++;
        $display("FAIL muldiv_outs: got %b expected %b", o.outs, e.outs);
      end
      n_checks++;
      if (o.stall !== e.stall) begin
        n_fail++;
        $display("FAIL muldiv_stall: got %0d expected %0d", o.stall, e.stall);
      end
    end
  endtask

  task automatic test_dmem_busy();
    rec_t e, o;
    drive_step(1, 1, 0, 0, 1, 0, V_BUSY);
    drive_step(0, 0, 1, 0, 1, 0, V_BUSY);
    drive_step(0, 0, 1, 0, 0, 0, V_GO);
    drive_step(0, 0, 1, 0, 0, 0, V_FRZ);
    drive_step(0, 0, 1, 0, 0, 0, V_FRZ);
    for (int i = 0; i < 3; i++) drive_step(0, 0, 1, 0, 1, 0, V_BUSY);
    drive_step(0, 0, 1, 1, 0, 0, V_RUN);
    drive_step(0, 0, 0, 0, 0, 0, V_RUN);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.outs !== e.outs) begin
        n_fail++;
        $display("FAIL dmem_busy_outs: got %b expected %b", o.outs, e.outs);
      end
      n_checks++;
      if (o.stall !== e.stall) begin
        n_fail++;
        $display("FAIL dmem_busy_stall: got %0d expected %0d", o.stall, e.stall);
      end
    end
  endtask

  // 37 wait cycles, a 3-cycle memory freeze that must not advance the wait
  // count, then 3 more wait cycles: the flag must appear only after the 40th.
  task automatic test_timeout();
    rec_t e, o;
    drive_step(0, 0, 1, 0, 0, 0, V_GO);
    for (int i = 0; i < 37; i++) drive_step(0, 0, 1, 0, 0, 0, V_FRZ);
    for (int i = 0; i < 3; i++)  drive_step(0, 0, 1, 0, 1, 0, V_BUSY);
    for (int i = 0; i < 3; i++)  drive_step(0, 0, 1, 0, 0, 0, V_FRZ);
    drive_step(0, 0, 1, 0, 0, 0, V_FRZ | V_TO);
    drive_step(1, 1, 1, 0, 0, 0, V_FRZ | V_TO);
    drive_step(0, 0, 1, 0, 0, 1, V_RST | V_TO);
    drive_step(0, 0, 0, 0, 0, 0, V_RUN);
    drive_step(1, 0, 0, 0, 0, 0, V_LDUSE);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.outs !== e.outs) begin
        n_fail++;
        $display("FAIL timeout_outs: got %b expected %b", o.outs, e.outs);
      end
      n_checks++;
      if (o.stall !== e.stall) begin
        n_fail++;
        $display("FAIL timeout_stall: got %0d expected %0d", o.stall, e.stall);
      end
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    exp_stall    = '0;
    RESET        = 1'b1;
    LOAD_USE_HAZ = 1'b0;
    BRANCH_TAKEN = 1'b0;
    MULDIV_OP    = 1'b0;
    MULDIV_DONE  = 1'b0;
    DMEM_BUSY    = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_muldiv();
    test_dmem_busy();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_hazard_stall_ctrl
`default_nettype wire

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have port CLK  input  1  single pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-003 SHALL have port LOAD_USE_HAZ  input  1  load-use stall request from the hazard detection unit (ID stage).
REQ-004 SHALL have port BRANCH_TAKEN  input  1  taken branch/jump resolved in EX.
REQ-005 SHALL have port MULDIV_OP  input  1  EX-stage instruction is an M-extension op.
REQ-006 SHALL have port MULDIV_DONE  input  1  multi-cycle mul/div unit result valid.
REQ-007 SHALL have port DMEM_BUSY  input  1  data memory not ready.
REQ-008 SHALL have ports PC_WRITE_EN, IF_ID_WRITE_EN, ID_EX_WRITE_EN, EX_MEM_WRITE_EN, MEM_WB_WRITE_EN  output  1 each  pipeline register load enables.
REQ-009 SHALL have ports IF_ID_FLUSH, ID_EX_BUBBLE, EX_MEM_BUBBLE  output  1 each  force NOP into that register.
REQ-010 SHALL have port MULDIV_GO  output  1  one-cycle start pulse to the mul/div unit.
REQ-011 SHALL have port MD_TIMEOUT  output  1  sticky error flag.
REQ-012 SHALL have port STALL_CNT  output  32  count of cycles with PC_WRITE_EN low.
REQ-013 SHALL have parameter MD_TIMEOUT_CYC, default 40, max mul/div wait cycles before MD_TIMEOUT sets.

Function
REQ-014 SHALL implement FSM states RUN, MD_WAIT; enables/bubbles are combinational decode of state and inputs.
REQ-015 RUN, no requests: all WRITE_EN = 1, all FLUSH/BUBBLE = 0.
REQ-016 RUN, LOAD_USE_HAZ = 1: PC_WRITE_EN = IF_ID_WRITE_EN = 0, ID_EX_BUBBLE = 1, later stages enabled; exactly one bubble per request cycle.
REQ-017 RUN, BRANCH_TAKEN = 1: IF_ID_FLUSH = ID_EX_BUBBLE = 1, PC_WRITE_EN = 1; overrides LOAD_USE_HAZ in same cycle (no PC freeze).
REQ-018 RUN, MULDIV_OP = 1 and BRANCH_TAKEN = 0: MULDIV_GO = 1 that cycle, PC/IF_ID/ID_EX/EX_MEM enables = 0, EX_MEM_BUBBLE = 1; next state MD_WAIT.
REQ-019 MD_WAIT, MULDIV_DONE = 0: same freeze as REQ-018, MULDIV_GO = 0, MEM_WB_WRITE_EN = 1; wait counter increments.
REQ-020 MD_WAIT, MULDIV_DONE = 1: all enables 1, EX_MEM_BUBBLE = 0; next state RUN; LOAD_USE_HAZ/BRANCH_TAKEN ignored that cycle.
REQ-021 DMEM_BUSY = 1 in any state: all five WRITE_EN = 0 and all FLUSH/BUBBLE = 0 (full freeze, highest priority); FSM state and wait counter hold; MULDIV_GO suppressed and re-issued when DMEM_BUSY drops.
REQ-022 Wait counter 6-bit, saturating; reaching MD_TIMEOUT_CYC sets MD_TIMEOUT, which stays 1 until RESET; FSM stays in MD_WAIT.
REQ-023 STALL_CNT increments by 1 each cycle PC_WRITE_EN = 0 (excluding reset cycles), wraps 0xFFFFFFFF -> 0.

Reset
REQ-024 RESET = 1 at edge: state = RUN, wait counter = 0, MD_TIMEOUT = 0, STALL_CNT = 0.
REQ-025 While RESET = 1: all WRITE_EN = 0, IF_ID_FLUSH = ID_EX_BUBBLE = EX_MEM_BUBBLE = 1, MULDIV_GO = 0.
REQ-026 RESET mid-MD_WAIT SHALL abandon the wait without issuing MULDIV_GO.

Structure
REQ-027 FSM state encoding and MD_TIMEOUT_CYC default SHALL live in the shared pipeline package.
REQ-028 STALL_CNT SHALL be a sub-module perf_counter (enable, sync clear, 32-bit wrap).

Verification
REQ-029 LOAD_USE_HAZ = 1 for 1 cycle in RUN -> PC_WRITE_EN = 0, ID_EX_BUBBLE = 1 that cycle only; STALL_CNT = 1.
REQ-030 BRANCH_TAKEN = 1 and LOAD_USE_HAZ = 1 same cycle -> IF_ID_FLUSH = ID_EX_BUBBLE = 1, PC_WRITE_EN = 1; STALL_CNT unchanged.
REQ-031 MULDIV_OP = 1, MULDIV_DONE after 5 cycles -> one MULDIV_GO pulse, 6 frozen cycles, STALL_CNT = 6, state RUN.
REQ-032 DMEM_BUSY = 1 for 3 cycles during MD_WAIT -> all enables 0, wait counter holds; MULDIV_DONE afterwards releases normally.
REQ-033 MULDIV_DONE never asserted -> MD_TIMEOUT = 1 after 40 MD_WAIT cycles; RESET clears it, state RUN, STALL_CNT = 0.
